// File: rtl/fb_pkg.sv
// fb_pkg: shared constants, types and helpers for the framebuffer write path.
//   SCREEN_W / SCREEN_H : visible resolution (800 x 480)
//   FB_ADDR_W           : framebuffer RAM address width
//   coord_t             : 11-bit coordinate, wide enough that x0+w / y0+h never wrap
//   idx_t               : linear pixel index, wide enough for out-of-screen rows
//   state_t             : writer FSM states
//   mul_const()         : shift-and-add product of a coordinate and a constant
package fb_pkg;

    localparam int SCREEN_W  = 800;
    localparam int SCREEN_H  = 480;
    localparam int FB_ADDR_W = 19;
    localparam int COORD_W   = 11;
    // Largest reachable row is 1023+1023-1 = 2045; 2045*800 needs 21 bits.
    localparam int IDX_W     = 21;

    typedef logic [FB_ADDR_W-1:0] fb_addr_t;
    typedef logic [3:0]           color_idx_t;
    typedef logic [COORD_W-1:0]   coord_t;
    typedef logic [IDX_W-1:0]     idx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        FINISH = 2'd2
    } state_t;

    // y * k built from shifted copies of y, one per set bit of the constant k.
    // With k a constant this folds into a few adders, no multiplier.
    function automatic idx_t mul_const(input coord_t y, input int k);
        idx_t acc;
        acc = '0;
        for (int i = 0; i < IDX_W; i++) begin
            if (k[i]) begin
                acc = acc + (idx_t'(y) << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// fb_addr_gen: row-major pixel walker for rectangle fills.
// Holds the x/y counters, the row-base accumulator (y*SCREEN_W, no multiplier)
// and the rectangle bounds. The outputs describe the pixel that will be issued
// at the next clock edge when start or step is high, so the caller can
// register them straight into the RAM write port.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : load a new rectangle (x0, y0, w, h); next pixel = (x0, y0)
//   step       : advance to the pixel after the current one
//   x0,y0,w,h  : rectangle, only sampled while start is high
//   addr       : RAM address of the next pixel (halved when HALF_ADDR != 0)
//   in_bounds  : next pixel lies on the visible screen
//   last       : next pixel is the final pixel of the rectangle
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter int HALF_ADDR = 0,
    parameter int ADDR_W    = FB_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               step,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] w,
    input  logic [COORD_W-1:0] h,
    output logic [ADDR_W-1:0]  addr,
    output logic               in_bounds,
    output logic               last
);

    localparam coord_t SCREEN_W_C = coord_t'(SCREEN_W);
    localparam coord_t SCREEN_H_C = coord_t'(SCREEN_H);

    coord_t x_q, y_q, x0_q, x_end_q, y_end_q;
    idx_t   row_q;

    coord_t nx, ny, nx_end, ny_end;
    idx_t   nrow, idx;

    always_comb begin
        nx     = x_q;
        ny     = y_q;
        nrow   = row_q;
        nx_end = x_end_q;
        ny_end = y_end_q;
        if (start) begin
            nx     = x0;
            ny     = y0;
            nrow   = mul_const(y0, SCREEN_W);
            nx_end = x0 + w;
            ny_end = y0 + h;
        end else if (x_q + coord_t'(1) == x_end_q) begin
            // End of row: restart at the left column one row down.
            nx   = x0_q;
            ny   = y_q + coord_t'(1);
            nrow = row_q + idx_t'(SCREEN_W);
        end else begin
            nx = x_q + coord_t'(1);
        end
    end

    always_comb begin
        idx       = nrow + idx_t'(nx);
        in_bounds = (nx < SCREEN_W_C) && (ny < SCREEN_H_C);
        last      = (nx + coord_t'(1) == nx_end) && (ny + coord_t'(1) == ny_end);
        // In half mode the two pixels of a pair share one RAM word.
        addr      = ADDR_W'((HALF_ADDR != 0) ? (idx >> 1) : idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            x0_q    <= '0;
            x_end_q <= '0;
            y_end_q <= '0;
            row_q   <= '0;
        end else begin
            if (start) begin
                x0_q    <= x0;
                x_end_q <= nx_end;
                y_end_q <= ny_end;
            end
            if (start || step) begin
                x_q   <= nx;
                y_q   <= ny;
                row_q <= nrow;
            end
        end
    end

endmodule

// File: rtl/fb_writer.sv
// fb_writer: rectangle-fill engine for the VGA framebuffer write port.
// Accepts one fill command at a time and writes one 4-bit colour index per
// clock, row-major, using the scan-out addressing (y*800 + x, halved for the
// small a35t framebuffer). Off-screen pixels take their cycle with fb_we=0.
// Optional feature macro: FB_WRITER_CLEAR_EN adds the clear port, a
// full-screen fill with colour 0 that wins over cmd_valid while idle.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   clear           : full-screen clear request (FB_WRITER_CLEAR_EN only)
//   cmd_valid/ready : command handshake
//   cmd_x0, cmd_y0  : top-left corner
//   cmd_w, cmd_h    : size, zero allowed (no writes, just a done pulse)
//   cmd_color       : colour index
//   fb_we/addr/data : RAM write port, registered
//   busy            : fill in progress
//   done            : one-cycle pulse after the last pixel cycle
module fb_writer
    import fb_pkg::*;
#(
    parameter int FRAMEBUFFER_SIZE = 384000,
    parameter int HALF_ADDR        = (FRAMEBUFFER_SIZE > 192000 ? 0 : 1),
    parameter int ADDR_W           = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
`ifdef FB_WRITER_CLEAR_EN
    input  logic              clear,
`endif
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x0,
    input  logic [9:0]        cmd_y0,
    input  logic [9:0]        cmd_w,
    input  logic [9:0]        cmd_h,
    input  logic [3:0]        cmd_color,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [3:0]        fb_data,
    output logic              busy,
    output logic              done
);

    state_t     state;
    logic       in_idle;
    logic       accept_cmd, accept_clr, accept;
    logic       zero_area, start, step, load;
    coord_t     sel_x0, sel_y0, sel_w, sel_h;
    color_idx_t sel_color, color_q, data_q;
    logic       we_q, last_q;

    logic [ADDR_W-1:0] nxt_addr;
    logic              nxt_in_bounds, nxt_last;

    assign in_idle = (state == IDLE);

`ifdef FB_WRITER_CLEAR_EN
    assign accept_clr = in_idle & ~rst & clear;
`else
    assign accept_clr = 1'b0;
`endif

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high. cmd_ready depends only on state and rst (and a
    // competing clear), never on cmd_valid, and all cmd_* fields are captured
    // on that edge; they are ignored until the next transfer.
    assign cmd_ready  = in_idle & ~rst & ~accept_clr;
    assign accept_cmd = cmd_valid & cmd_ready;
    assign accept     = accept_cmd | accept_clr;

    always_comb begin
        sel_x0    = {1'b0, cmd_x0};
        sel_y0    = {1'b0, cmd_y0};
        sel_w     = {1'b0, cmd_w};
        sel_h     = {1'b0, cmd_h};
        sel_color = cmd_color;
        if (accept_clr) begin
            sel_x0    = '0;
            sel_y0    = '0;
            sel_w     = coord_t'(SCREEN_W);
            sel_h     = coord_t'(SCREEN_H);
            sel_color = '0;
        end
    end

    assign zero_area = (sel_w == '0) || (sel_h == '0);
    assign start     = accept & ~zero_area;
    // last_q marks the pixel currently on the write port as the final one.
    assign step      = (state == FILL) & ~last_q;
    assign load      = start | step;

    fb_addr_gen #(
        .HALF_ADDR (HALF_ADDR),
        .ADDR_W    (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .step      (step),
        .x0        (sel_x0),
        .y0        (sel_y0),
        .w         (sel_w),
        .h         (sel_h),
        .addr      (nxt_addr),
        .in_bounds (nxt_in_bounds),
        .last      (nxt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            fb_addr <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            color_q <= '0;
        end else begin
            we_q   <= load & nxt_in_bounds;
            data_q <= (load & nxt_in_bounds) ? (start ? sel_color : color_q) : '0;
            if (load) begin
                fb_addr <= nxt_addr;
                last_q  <= nxt_last;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        color_q <= sel_color;
                        state   <= zero_area ? FINISH : FILL;
                    end
                end
                FILL: begin
                    if (last_q) begin
                        state <= FINISH;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Reset aborts the write in the very cycle it is asserted, not one later.
    assign fb_we   = we_q & ~rst;
    assign fb_data = rst ? 4'd0 : data_q;
    assign busy    = (state == FILL);
    assign done    = (state == FINISH);

endmodule

// File: tb/tb_fb_writer.sv
// tb_fb_writer: bench for fb_writer. Two instances (full and half addressing)
// share one stimulus stream; a rectangle-level model expands every accepted
// command into its per-cycle outputs and a compare process checks both
// instances each cycle, alongside directed cases with literal expectations.
module tb_fb_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [9:0] cmd_x0, cmd_y0, cmd_w, cmd_h;
    logic [3:0] cmd_color;
`ifdef FB_WRITER_CLEAR_EN
    logic       clear = 1'b0;
`endif

    logic        f_ready, f_we, f_busy, f_done;
    logic [18:0] f_addr;
    logic [3:0]  f_data;
    logic        h_ready, h_we, h_busy, h_done;
    logic [18:0] h_addr;
    logic [3:0]  h_data;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    fb_writer #(.FRAMEBUFFER_SIZE(384000)) dut_full (
        .clk       (clk),
        .rst       (rst),
`ifdef FB_WRITER_CLEAR_EN
        .clear     (clear),
`endif
        .cmd_valid (cmd_valid),
        .cmd_ready (f_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .fb_we     (f_we),
        .fb_addr   (f_addr),
        .fb_data   (f_data),
        .busy      (f_busy),
        .done      (f_done)
    );

    fb_writer #(.FRAMEBUFFER_SIZE(192000)) dut_half (
        .clk       (clk),
        .rst       (rst),
`ifdef FB_WRITER_CLEAR_EN
        .clear     (clear),
`endif
        .cmd_valid (cmd_valid),
        .cmd_ready (h_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .fb_we     (h_we),
        .fb_addr   (h_addr),
        .fb_data   (h_data),
        .busy      (h_busy),
        .done      (h_done)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        we;
        logic [18:0] af;
        logic [18:0] ah;
        logic [3:0]  data;
        logic        busy;
        logic        done;
    } ent_t;

    ent_t exp_q[$];
    ent_t cur   = '0;
    logic m_acc = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Expand one rectangle into the cycles it must occupy: one entry per
    // pixel in row-major order, then the done cycle.
    function automatic void push_cmd(input int x0, input int y0, input int w, input int h, input int c);
        ent_t e;
        int x, y, idx;
        for (int j = 0; j < h; j++) begin
            for (int i = 0; i < w; i++) begin
                x      = x0 + i;
                y      = y0 + j;
                idx    = y * 800 + x;
                e.we   = (x < 800) && (y < 480);
                e.af   = 19'(idx);
                e.ah   = 19'(idx / 2);
                e.data = e.we ? c[3:0] : 4'd0;
                e.busy = 1'b1;
                e.done = 1'b0;
                exp_q.push_back(e);
            end
        end
        e      = '0;
        e.done = 1'b1;
        exp_q.push_back(e);
    endfunction

    // Model: 'cur' is what the outputs must show during the cycle that
    // begins at this edge.
    always @(posedge clk) begin
        m_acc = 1'b0;
        if (rst) begin
            exp_q.delete();
            cur = '0;
        end else begin
            if (!cur.busy && !cur.done && cmd_valid) begin
                m_acc = 1'b1;
                push_cmd(int'(cmd_x0), int'(cmd_y0), int'(cmd_w), int'(cmd_h), int'(cmd_color));
            end
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else                  cur = '0;
        end
    end

    logic [26:0] exp_f, act_f, exp_h, act_h;
    logic        e_we, e_rdy;

    always @(negedge clk) begin
        e_we  = cur.we && !rst;
        e_rdy = !cur.busy && !cur.done && !rst;
        exp_f = {e_rdy, cur.busy, cur.done, e_we, e_we ? cur.data : 4'd0, e_we ? cur.af : 19'd0};
        act_f = {f_ready, f_busy, f_done, f_we, f_data, e_we ? f_addr : 19'd0};
        exp_h = {e_rdy, cur.busy, cur.done, e_we, e_we ? cur.data : 4'd0, e_we ? cur.ah : 19'd0};
        act_h = {h_ready, h_busy, h_done, h_we, h_data, e_we ? h_addr : 19'd0};
        chk("cyc_full", 32'(act_f), 32'(exp_f));
        chk("cyc_half", 32'(act_h), 32'(exp_h));
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        cmd_x0    = 10'($urandom_range(0, 1023));
        cmd_y0    = 10'($urandom_range(0, 1023));
        cmd_w     = 10'($urandom_range(0, 1023));
        cmd_h     = 10'($urandom_range(0, 1023));
        cmd_color = 4'($urandom_range(0, 15));
    endtask

    // Returns in the first cycle after acceptance (first pixel on the port).
    task automatic send(input int x0, input int y0, input int w, input int h, input int c);
        int k;
        cmd_x0    = 10'(x0);
        cmd_y0    = 10'(y0);
        cmd_w     = 10'(w);
        cmd_h     = 10'(h);
        cmd_color = 4'(c);
        cmd_valid = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (!m_acc && k < 100);
        chk("accept", 32'(m_acc), 32'd1);
        cmd_valid = 1'b0;
        scramble();
    endtask

    function automatic logic [9:0] pick(input int edge_v);
        case ($urandom_range(0, 3))
            0:       return 10'($urandom_range(0, 7));
            1:       return 10'($urandom_range(edge_v - 5, edge_v));
            2:       return 10'($urandom_range(0, 1023));
            default: return 10'($urandom_range(edge_v + 1, edge_v + 6));
        endcase
    endfunction

    int a2[4] = '{383198, 383199, 383998, 383999};

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        scramble();
        repeat (3) tick();
        chk("ready_in_rst", 32'(f_ready), 32'd0);
        chk("we_in_rst", 32'(f_we), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(f_ready), 32'd1);

        // 1x1 at (0,0), colour 5
        send(0, 0, 1, 1, 5);
        chk("t1_we", 32'(f_we), 32'd1);
        chk("t1_addr", 32'(f_addr), 32'd0);
        chk("t1_data", 32'(f_data), 32'd5);
        tick();
        chk("t1_done", 32'(f_done), 32'd1);
        chk("t1_we_off", 32'(f_we), 32'd0);
        tick();
        chk("t1_ready", 32'(f_ready), 32'd1);

        // 2x2 at the bottom-right corner
        send(798, 478, 2, 2, 3);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            chk("t2_we", 32'(f_we), 32'd1);
            chk("t2_addr", 32'(f_addr), 32'(a2[k]));
        end
        tick();
        chk("t2_done", 32'(f_done), 32'd1);

        // 3x1 at (799,0): only the first pixel is on screen
        send(799, 0, 3, 1, 9);
        chk("t3_we0", 32'(f_we), 32'd1);
        chk("t3_addr0", 32'(f_addr), 32'd799);
        for (int k = 1; k < 3; k++) begin
            tick();
            chk("t3_we_clip", 32'(f_we), 32'd0);
            chk("t3_busy", 32'(f_busy), 32'd1);
        end
        tick();
        chk("t3_done", 32'(f_done), 32'd1);
        chk("t3_busy_end", 32'(f_busy), 32'd0);

        // zero width
        send(100, 100, 0, 5, 4);
        chk("t4_done", 32'(f_done), 32'd1);
        chk("t4_we", 32'(f_we), 32'd0);
        chk("t4_busy", 32'(f_busy), 32'd0);

        // half addressing: (10,1) and (11,1) share word 405
        send(10, 1, 2, 1, 7);
        for (int k = 0; k < 2; k++) begin
            if (k > 0) tick();
            chk("t5_we", 32'(h_we), 32'd1);
            chk("t5_addr", 32'(h_addr), 32'd405);
            chk("t5_data", 32'(h_data), 32'd7);
        end

        // reset on the third write of a 4x4 fill
        send(50, 60, 4, 4, 2);
        tick();
        tick();
        chk("t6_we_pre", 32'(f_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_we_rst", 32'(f_we), 32'd0);
        chk("t6_we_rst_h", 32'(h_we), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t6_ready", 32'(f_ready), 32'd1);
        chk("t6_busy", 32'(f_busy), 32'd0);
        tick();
        chk("t6_no_done", 32'(f_done), 32'd0);

        // random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_x0    = pick(799);
            cmd_y0    = pick(479);
            cmd_w     = 10'($urandom_range(0, 5));
            cmd_h     = 10'($urandom_range(0, 3));
            cmd_color = 4'($urandom_range(0, 15));
            rst       = ($urandom_range(0, 249) == 0);
            tick();
        end
        cmd_valid = 1'b0;
        rst       = 1'b0;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fb_writer.md
Name: fb_writer

Overview:
- Write-side counterpart of the VGA framebuffer read path.
- Accepts rectangle-fill commands and writes one 4-bit colour index per clock into the framebuffer RAM.
- Uses the same addressing as the scan-out reader: pixel index = y*800 + x, halved when the framebuffer is small (a35t).
- Sits between the game/render logic and the framebuffer BRAM write port.

Parameters:
- SCREEN_W, 800, visible width in pixels.
- SCREEN_H, 480, visible height in pixels.
- HALF_ADDR, (FRAMEBUFFER_SIZE > 192000 ? 0 : 1), 1 = address is pixel index / 2 (a35t build).
- ADDR_W, 19, framebuffer address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_x0  in  10  left column
- cmd_y0  in  10  top row
- cmd_w  in  10  width in pixels, 0 allowed
- cmd_h  in  10  height in pixels, 0 allowed
- cmd_color  in  4  colour index
- fb_we  out  1  RAM write enable
- fb_addr  out  19  RAM write address
- fb_data  out  4  RAM write data
- busy  out  1  fill in progress
- done  out  1  one-cycle pulse, command finished
- clear  in  1  full-screen clear request; only present with FB_WRITER_CLEAR_EN

Behaviour:
- Reset values:
  - fb_we=0, fb_addr=0, fb_data=0, busy=0, done=0.
  - cmd_ready=0 while rst is high; cmd_ready=1 in the first cycle after rst deasserts.
  - State returns to IDLE.
- States:
  - IDLE: cmd_ready=1.
  - FILL: busy=1.
  - FINISH: done=1 for one cycle, then IDLE.
- Handshake:
  - A command is accepted on a clk edge with cmd_valid & cmd_ready.
  - All cmd_* fields are registered at acceptance; later changes to them are ignored.
  - cmd_ready = (state==IDLE) & ~rst. No new command is accepted in FILL or FINISH.
- Zero area: if cmd_w==0 or cmd_h==0, the block goes IDLE -> FINISH directly. No writes occur; done pulses in the cycle after acceptance.
- FILL scan order:
  - Row-major, starting at (x0,y0), one pixel per cycle.
  - x runs x0 .. x0+w-1, then y advances and x restarts at x0.
  - FILL lasts exactly w*h cycles.
  - The first write appears in the cycle after acceptance.
  - All write outputs are registered.
- Clipping: a pixel with x >= SCREEN_W or y >= SCREEN_H still consumes its cycle, but fb_we=0 for that cycle. Coordinate arithmetic is 11 bits wide, so x0+w never wraps.
- Address generation:
  - No multiplier. A row-base register starts at y0*SCREEN_W (computed once at acceptance) and adds SCREEN_W per row.
  - pixel index = row_base + x.
  - fb_addr = HALF_ADDR ? index>>1 : index.
  - In half mode both pixels of a pair write the same address; the last write wins.
- fb_data = registered cmd_color whenever fb_we=1; 0 otherwise.
- After the last pixel cycle the block enters FINISH, with done=1 and busy=0, then returns to IDLE.
- Back-to-back: the earliest next acceptance is in the cycle after the done pulse.
- Reset mid-FILL: writes abort immediately (fb_we=0 in the cycle rst is sampled), no done pulse, state returns to IDLE.

Optional Feature:
- Macro: FB_WRITER_CLEAR_EN.
- Defined:
  - The clear port exists.
  - clear=1 while in IDLE takes priority over cmd_valid.
  - It behaves as a command with x0=0, y0=0, w=SCREEN_W, h=SCREEN_H, color=0.
  - While clear is accepted, cmd_ready=0 for that cycle.
- Undefined: the port is absent and no clear logic is built.

Decomposition:
- Package fb_pkg:
  - SCREEN_W, SCREEN_H, FB_ADDR_W.
  - typedefs fb_addr_t (19b), color_idx_t (4b), coord_t (11b).
  - state enum {IDLE, FILL, FINISH}.
- One sub-module, fb_addr_gen: owns the x/y counters, the row-base accumulator, the clip flag and the half-address shift. It takes start/step inputs and outputs addr, in_bounds and last.

Test Plan:
- 1x1 fill at (0,0), color 5 -> single cycle with fb_we=1, addr 0, data 5; done the next cycle; cmd_ready back to 1 after that.
- 2x2 fill at (798,478), color 3, full mode -> addrs 383198, 383199, 383998, 383999 on consecutive cycles; done after the 4th write.
- 3x1 fill at (799,0) -> cycle 1 writes addr 799; cycles 2-3 have fb_we=0; busy for 3 cycles, then done.
- cmd_w=0, cmd_h=5 -> no fb_we; done one cycle after acceptance.
- HALF_ADDR=1, 2x1 fill at (10,1), color 7 -> two writes, both addr 405, data 7.
- 4x4 fill with rst asserted on the 3rd write cycle -> fb_we=0 from that cycle, no done pulse, cmd_ready=1 one cycle after rst drops; with FB_WRITER_CLEAR_EN, a clear then gives 384000 cycles of busy, last addr 383999 (191999 in half mode).
